// File: rtl/core0_base_core.sv
`default_nettype none
// ============================================================================
// Module   : core0_base_core
// Purpose  : Stack-machine core for the uarc core0 family. Fetches byte-coded
//            variable-length instructions (1 byte, or 5 bytes with a 32-bit
//            immediate) and keeps data, call and loop stacks internally.
//            Talks to a word-addressed main memory and to other cores over
//            the uarc send/receive channels. Kill, incept and stream are tied
//            off.
// Ports    : clk, reset (async, active-low)
//            programmem_*  : fetch address / 5-byte read window / word write
//            mainmem_*     : 1-cycle-latency read port, write port
//            global_*      : outgoing word and handshake strobes
//            sender_*      : per-bus enable and acknowledge
//            receiver_*    : per-bus incoming words and accept pulses
// Revision : 1.0 - initial release
// ============================================================================
module core0_base_core #(
  parameter int WORD_MAG            = 5,
  parameter int UARC_SETS           = 1,
  parameter int TOTAL_BUSES         = 1,
  parameter int PROGRAM_ADDR_WIDTH  = 16,
  parameter int MAIN_ADDR_WIDTH     = 16,
  parameter int ASTACK_DEPTH        = 64,
  parameter int CSTACK_DEPTH        = 64,
  parameter int LSTACK_DEPTH        = 7,
  parameter int CONVEYOR_ADDR_WIDTH = 4,
  localparam int WORD_WIDTH         = 1 << WORD_MAG
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic [PROGRAM_ADDR_WIDTH-1:0]     programmem_addr,
  input  logic [8+WORD_WIDTH-1:0]           programmem_read_value,
  output logic [PROGRAM_ADDR_WIDTH-1:0]     programmem_write_addr,
  output logic [WORD_WIDTH-1:0]             programmem_write_mask,
  output logic [WORD_WIDTH-1:0]             programmem_write_value,
  output logic                              programmem_we,
  output logic [MAIN_ADDR_WIDTH-1:0]        mainmem_read_addr,
  output logic [MAIN_ADDR_WIDTH-1:0]        mainmem_write_addr,
  input  logic [WORD_WIDTH-1:0]             mainmem_read_value,
  output logic [WORD_WIDTH-1:0]             mainmem_write_value,
  output logic                              mainmem_we,
  output logic                              global_send,
  output logic [WORD_WIDTH-1:0]             global_data,
  output logic                              global_kill,
  output logic                              global_incept,
  output logic                              global_stream,
  output logic [WORD_WIDTH-1:0]             global_self_permission,
  output logic [WORD_WIDTH-1:0]             global_self_address,
  output logic [WORD_WIDTH-1:0]             global_incept_permission,
  output logic [WORD_WIDTH-1:0]             global_incept_address,
  output logic [TOTAL_BUSES-1:0]            sender_enables,
  input  logic [TOTAL_BUSES-1:0]            sender_send_acks,
  input  logic [TOTAL_BUSES-1:0]            sender_kill_acks,
  input  logic [TOTAL_BUSES-1:0]            sender_incept_acks,
  input  logic [TOTAL_BUSES-1:0]            sender_stream_acks,
  input  logic [TOTAL_BUSES-1:0]            receiver_enables,
  input  logic [TOTAL_BUSES-1:0]            receiver_sends,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
  output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
  input  logic [TOTAL_BUSES-1:0]            receiver_kills,
  input  logic [TOTAL_BUSES-1:0]            receiver_incepts,
  input  logic [TOTAL_BUSES-1:0]            receiver_streams,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_incept_permissions,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_incept_addresses,
  output logic [TOTAL_BUSES-1:0]            receiver_kill_acks,
  output logic [TOTAL_BUSES-1:0]            receiver_incept_acks,
  output logic [TOTAL_BUSES-1:0]            receiver_stream_acks
);

  localparam int AW = (ASTACK_DEPTH > 1) ? $clog2(ASTACK_DEPTH) : 1;
  localparam int CW = (CSTACK_DEPTH > 1) ? $clog2(CSTACK_DEPTH) : 1;
  localparam int LW = (LSTACK_DEPTH > 1) ? $clog2(LSTACK_DEPTH) : 1;
  localparam int BW = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

  localparam logic [2:0] S_FETCH = 3'd0, S_EXEC = 3'd1, S_LOAD = 3'd2,
                         S_SEND  = 3'd3, S_RECV = 3'd4, S_HALT = 3'd5;

  localparam logic [7:0] OP_LIT  = 8'h01, OP_DROP  = 8'h02, OP_DUP   = 8'h03,
                         OP_SWAP = 8'h04, OP_OVER  = 8'h05, OP_ADD   = 8'h06,
                         OP_SUB  = 8'h07, OP_AND   = 8'h08, OP_OR    = 8'h09,
                         OP_XOR  = 8'h0A, OP_LOAD  = 8'h0B, OP_STORE = 8'h0C,
                         OP_JUMP = 8'h0D, OP_JZ    = 8'h0E, OP_CALL  = 8'h0F,
                         OP_RET  = 8'h10, OP_SEND  = 8'h11, OP_RECV  = 8'h12,
                         OP_HALT = 8'h13, OP_PWR   = 8'h14, OP_LPUSH = 8'h15,
                         OP_LOOP = 8'h16, OP_BSEL  = 8'h17;

  // Stack pointers wrap modulo the (possibly non power-of-two) depth.
  function automatic int wrap(input int v, input int depth);
    int r;
    r = v % depth;
    if (r < 0) r = r + depth;
    return r;
  endfunction

  logic [2:0]                    state, state_nxt;
  logic [PROGRAM_ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [AW-1:0]                 sp, sp_nxt;
  logic [CW-1:0]                 csp, csp_nxt;
  logic [LW-1:0]                 lsp, lsp_nxt;
  logic [BW-1:0]                 bus_sel, bus_sel_nxt;
  logic [WORD_WIDTH-1:0]         send_data, send_data_nxt;

  logic [WORD_WIDTH-1:0]         astack [ASTACK_DEPTH];
  logic [PROGRAM_ADDR_WIDTH-1:0] cstack [CSTACK_DEPTH];
  logic [WORD_WIDTH-1:0]         lstack [LSTACK_DEPTH];

  // sp points at the next free slot; T is sp-1 and N is sp-2.
  logic [AW-1:0] sp_p1, sp_m1, sp_m2;
  logic [CW-1:0] csp_p1, csp_m1;
  logic [LW-1:0] lsp_p1, lsp_m1;
  assign sp_p1  = AW'(wrap(int'(sp) + 1, ASTACK_DEPTH));
  assign sp_m1  = AW'(wrap(int'(sp) - 1, ASTACK_DEPTH));
  assign sp_m2  = AW'(wrap(int'(sp) - 2, ASTACK_DEPTH));
  assign csp_p1 = CW'(wrap(int'(csp) + 1, CSTACK_DEPTH));
  assign csp_m1 = CW'(wrap(int'(csp) - 1, CSTACK_DEPTH));
  assign lsp_p1 = LW'(wrap(int'(lsp) + 1, LSTACK_DEPTH));
  assign lsp_m1 = LW'(wrap(int'(lsp) - 1, LSTACK_DEPTH));

  logic [7:0]                    opcode;
  logic [WORD_WIDTH-1:0]         imm, tos, nos, ltop, ltop_dec, alu;
  logic [PROGRAM_ADDR_WIDTH-1:0] target, pc_step;
  logic                          is_imm;
  assign opcode   = programmem_read_value[7:0];
  assign imm      = programmem_read_value[8 +: WORD_WIDTH];
  assign target   = imm[PROGRAM_ADDR_WIDTH-1:0];
  assign is_imm   = opcode inside {OP_LIT, OP_JUMP, OP_JZ, OP_CALL, OP_LOOP};
  assign pc_step  = is_imm ? PROGRAM_ADDR_WIDTH'(5) : PROGRAM_ADDR_WIDTH'(1);
  assign tos      = astack[sp_m1];
  assign nos      = astack[sp_m2];
  assign ltop     = lstack[lsp_m1];
  assign ltop_dec = ltop - WORD_WIDTH'(1);

  always_comb begin
    case (opcode)
      OP_ADD:  alu = nos + tos;
      OP_SUB:  alu = nos - tos;
      OP_AND:  alu = nos & tos;
      OP_OR:   alu = nos | tos;
      default: alu = nos ^ tos;
    endcase
  end

  // Lowest-numbered bus with a pending, enabled word wins.
  logic                   recv_hit;
  logic [WORD_WIDTH-1:0]  recv_data;
  logic [TOTAL_BUSES-1:0] recv_onehot;
  always_comb begin
    recv_hit    = 1'b0;
    recv_data   = '0;
    recv_onehot = '0;
    for (int i = TOTAL_BUSES - 1; i >= 0; i--) begin
      if (receiver_sends[i] && receiver_enables[i]) begin
        recv_hit    = 1'b1;
        recv_data   = receiver_datas[i*WORD_WIDTH +: WORD_WIDTH];
        recv_onehot = TOTAL_BUSES'(1) << i;
      end
    end
  end

  logic send_ack;
  assign send_ack = |(sender_send_acks & sender_enables);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_LOAD: state_nxt = S_LOAD;
          OP_SEND: state_nxt = S_SEND;
          OP_RECV: state_nxt = S_RECV;
          OP_HALT: state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_LOAD:  state_nxt = S_FETCH;
      S_SEND:  if (send_ack) state_nxt = S_FETCH;
      S_RECV:  if (recv_hit) state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    global_send            = 1'b0;
    sender_enables         = '0;
    receiver_send_acks     = '0;
    mainmem_read_addr      = '0;
    mainmem_write_addr     = '0;
    mainmem_write_value    = '0;
    mainmem_we             = 1'b0;
    programmem_write_addr  = '0;
    programmem_write_mask  = '0;
    programmem_write_value = '0;
    programmem_we          = 1'b0;
    case (state)
      S_EXEC: begin
        case (opcode)
          OP_LOAD: mainmem_read_addr = tos[MAIN_ADDR_WIDTH-1:0];
          OP_STORE: begin
            mainmem_we          = 1'b1;
            mainmem_write_addr  = tos[MAIN_ADDR_WIDTH-1:0];
            mainmem_write_value = nos;
          end
          OP_PWR: begin
            programmem_we          = 1'b1;
            programmem_write_addr  = tos[PROGRAM_ADDR_WIDTH-1:0];
            programmem_write_mask  = '1;
            programmem_write_value = nos;
          end
          default: ;
        endcase
      end
      S_SEND: begin
        global_send    = 1'b1;
        sender_enables = TOTAL_BUSES'(1) << bus_sel;
      end
      S_RECV:  receiver_send_acks = recv_onehot;
      default: ;
    endcase
  end

  assign programmem_addr          = pc;
  assign global_data              = send_data;
  assign global_kill              = 1'b0;
  assign global_incept            = 1'b0;
  assign global_stream            = 1'b0;
  assign global_self_permission   = '0;
  assign global_self_address      = '0;
  assign global_incept_permission = '0;
  assign global_incept_address    = '0;
  assign receiver_kill_acks       = '0;
  assign receiver_incept_acks     = '0;
  assign receiver_stream_acks     = '0;

  // ---------------- Datapath next-state ----------------
  logic                          a_we0, a_we1, c_we, l_we;
  logic [AW-1:0]                 a_wa0, a_wa1;
  logic [LW-1:0]                 l_wa;
  logic [WORD_WIDTH-1:0]         a_wd0, a_wd1, l_wd;
  logic [PROGRAM_ADDR_WIDTH-1:0] c_wd;

  always_comb begin
    pc_nxt        = pc;
    sp_nxt        = sp;
    csp_nxt       = csp;
    lsp_nxt       = lsp;
    bus_sel_nxt   = bus_sel;
    send_data_nxt = send_data;
    a_we0 = 1'b0; a_wa0 = '0; a_wd0 = '0;
    a_we1 = 1'b0; a_wa1 = '0; a_wd1 = '0;
    c_we  = 1'b0; c_wd  = '0;
    l_we  = 1'b0; l_wa  = '0; l_wd  = '0;
    case (state)
      S_EXEC: begin
        pc_nxt = pc + pc_step;
        case (opcode)
          OP_LIT:  begin a_we0 = 1'b1; a_wa0 = sp; a_wd0 = imm; sp_nxt = sp_p1; end
          OP_DROP: sp_nxt = sp_m1;
          OP_DUP:  begin a_we0 = 1'b1; a_wa0 = sp; a_wd0 = tos; sp_nxt = sp_p1; end
          OP_SWAP: begin
            a_we0 = 1'b1; a_wa0 = sp_m1; a_wd0 = nos;
            a_we1 = 1'b1; a_wa1 = sp_m2; a_wd1 = tos;
          end
          OP_OVER: begin a_we0 = 1'b1; a_wa0 = sp; a_wd0 = nos; sp_nxt = sp_p1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            a_we0 = 1'b1; a_wa0 = sp_m2; a_wd0 = alu; sp_nxt = sp_m1;
          end
          OP_STORE, OP_PWR: sp_nxt = sp_m2;
          OP_JUMP: pc_nxt = target;
          OP_JZ: begin
            sp_nxt = sp_m1;
            if (tos == '0) pc_nxt = target;
          end
          OP_CALL: begin
            c_we = 1'b1; c_wd = pc + PROGRAM_ADDR_WIDTH'(5);
            csp_nxt = csp_p1; pc_nxt = target;
          end
          OP_RET:  begin pc_nxt = cstack[csp_m1]; csp_nxt = csp_m1; end
          OP_SEND: begin send_data_nxt = tos; sp_nxt = sp_m1; end
          OP_LPUSH: begin
            l_we = 1'b1; l_wa = lsp; l_wd = tos;
            lsp_nxt = lsp_p1; sp_nxt = sp_m1;
          end
          OP_LOOP: begin
            if (ltop_dec != '0) begin
              l_we = 1'b1; l_wa = lsp_m1; l_wd = ltop_dec; pc_nxt = target;
            end else begin
              lsp_nxt = lsp_m1;
            end
          end
          OP_BSEL: begin
            bus_sel_nxt = BW'(tos % WORD_WIDTH'(TOTAL_BUSES));
            sp_nxt      = sp_m1;
          end
          default: ;
        endcase
      end
      // Loaded word replaces T in place.
      S_LOAD: begin a_we0 = 1'b1; a_wa0 = sp_m1; a_wd0 = mainmem_read_value; end
      S_RECV: begin
        if (recv_hit) begin
          a_we0 = 1'b1; a_wa0 = sp; a_wd0 = recv_data; sp_nxt = sp_p1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      sp        <= '0;
      csp       <= '0;
      lsp       <= '0;
      bus_sel   <= '0;
      send_data <= '0;
    end else begin
      pc        <= pc_nxt;
      sp        <= sp_nxt;
      csp       <= csp_nxt;
      lsp       <= lsp_nxt;
      bus_sel   <= bus_sel_nxt;
      send_data <= send_data_nxt;
    end
  end

  // Stack storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (a_we0) astack[a_wa0] <= a_wd0;
    if (a_we1) astack[a_wa1] <= a_wd1;
    if (c_we)  cstack[csp]   <= c_wd;
    if (l_we)  lstack[l_wa]  <= l_wd;
  end

  logic unused_inputs;
  assign unused_inputs = &{1'b0, sender_kill_acks, sender_incept_acks,
                           sender_stream_acks, receiver_kills, receiver_incepts,
                           receiver_streams, receiver_incept_permissions,
                           receiver_incept_addresses, (UARC_SETS != 0),
                           (CONVEYOR_ADDR_WIDTH != 0)};

endmodule
`default_nettype wire

// File: tb/tb_core0_base_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_core0_base_core
// Purpose  : Self-checking bench for core0_base_core. Runs small hand-assembled
//            programs from a table, collects sent words, store/pwrite traffic
//            and receive accepts, and compares against hand-computed results.
//            Extra sequences cover reset state, send handshake timing and
//            reset during a pending send.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core0_base_core;

  localparam int WW = 32;
  localparam int PAW = 16;
  localparam int MAW = 16;
  localparam int NB = 1;

  localparam logic [7:0] LIT = 8'h01, DROP = 8'h02, DUP = 8'h03, SWAP = 8'h04,
                         OVER = 8'h05, ADD = 8'h06, SUB = 8'h07, AND = 8'h08,
                         OR = 8'h09, XOR = 8'h0A, LOAD = 8'h0B, STORE = 8'h0C,
                         JZ = 8'h0E, CALL = 8'h0F, RET = 8'h10, SEND = 8'h11,
                         RECV = 8'h12, HALT = 8'h13, PWR = 8'h14, LPUSH = 8'h15,
                         LOOP = 8'h16, BSEL = 8'h17;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [PAW-1:0]   programmem_addr, programmem_write_addr;
  logic [8+WW-1:0]  programmem_read_value = '0;
  logic [WW-1:0]    programmem_write_mask, programmem_write_value;
  logic             programmem_we;
  logic [MAW-1:0]   mainmem_read_addr, mainmem_write_addr;
  logic [WW-1:0]    mainmem_read_value = '0;
  logic [WW-1:0]    mainmem_write_value;
  logic             mainmem_we, global_send, global_kill, global_incept, global_stream;
  logic [WW-1:0]    global_data, global_self_permission, global_self_address;
  logic [WW-1:0]    global_incept_permission, global_incept_address;
  logic [NB-1:0]    sender_enables;
  logic [NB-1:0]    sender_send_acks = '0;
  logic [NB-1:0]    receiver_enables = '1;
  logic [NB-1:0]    receiver_sends = '1;
  logic [NB*WW-1:0] receiver_datas = 32'h0000_1234;
  logic [NB-1:0]    receiver_send_acks, receiver_kill_acks, receiver_incept_acks, receiver_stream_acks;

  core0_base_core dut (
    .clk(clk), .reset(reset),
    .programmem_addr(programmem_addr), .programmem_read_value(programmem_read_value),
    .programmem_write_addr(programmem_write_addr), .programmem_write_mask(programmem_write_mask),
    .programmem_write_value(programmem_write_value), .programmem_we(programmem_we),
    .mainmem_read_addr(mainmem_read_addr), .mainmem_write_addr(mainmem_write_addr),
    .mainmem_read_value(mainmem_read_value), .mainmem_write_value(mainmem_write_value),
    .mainmem_we(mainmem_we), .global_send(global_send), .global_data(global_data),
    .global_kill(global_kill), .global_incept(global_incept), .global_stream(global_stream),
    .global_self_permission(global_self_permission), .global_self_address(global_self_address),
    .global_incept_permission(global_incept_permission), .global_incept_address(global_incept_address),
    .sender_enables(sender_enables), .sender_send_acks(sender_send_acks),
    .sender_kill_acks('0), .sender_incept_acks('0), .sender_stream_acks('0),
    .receiver_enables(receiver_enables), .receiver_sends(receiver_sends),
    .receiver_datas(receiver_datas), .receiver_send_acks(receiver_send_acks),
    .receiver_kills('0), .receiver_incepts('0), .receiver_streams('0),
    .receiver_incept_permissions('0), .receiver_incept_addresses('0),
    .receiver_kill_acks(receiver_kill_acks), .receiver_incept_acks(receiver_incept_acks),
    .receiver_stream_acks(receiver_stream_acks)
  );

  always #5 clk = ~clk;

  // Program memory: 5-byte little-endian window, one cycle after the address.
  // Main memory: one-cycle read latency, write on the edge.
  logic [7:0]  pmem [0:255];
  logic [31:0] mmem [0:255];
  always @(posedge clk) begin
    programmem_read_value <= {pmem[8'(programmem_addr[7:0] + 8'd4)], pmem[8'(programmem_addr[7:0] + 8'd3)],
                              pmem[8'(programmem_addr[7:0] + 8'd2)], pmem[8'(programmem_addr[7:0] + 8'd1)],
                              pmem[programmem_addr[7:0]]};
    mainmem_read_value <= mmem[mainmem_read_addr[7:0]];
    if (mainmem_we) mmem[mainmem_write_addr[7:0]] <= mainmem_write_value;
  end

  // Send responder and traffic monitor, acting on the falling edge.
  int ack_delay = 1;
  int ack_cnt = 0;
  int we_cnt = 0, rack_cnt = 0, pw_cnt = 0;
  logic [31:0] pw_addr = '0, pw_val = '0, pw_mask = '0;
  logic [31:0] sent_q[$];
  always @(negedge clk) begin
    if (global_send) begin
      ack_cnt = ack_cnt + 1;
      if (ack_cnt >= ack_delay && sender_send_acks == '0) begin
        sender_send_acks = '1;
        sent_q.push_back(global_data);
      end
    end else begin
      ack_cnt = 0;
      sender_send_acks = '0;
    end
    if (mainmem_we) we_cnt++;
    if (receiver_send_acks != '0) rack_cnt++;
    if (programmem_we) begin
      pw_cnt++;
      pw_addr = 32'(programmem_write_addr);
      pw_val  = programmem_write_value;
      pw_mask = programmem_write_mask;
    end
  end

  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // code: byte i at bits [8*i +: 8]; concatenations below list bytes last-to-first.
  // exp: send k at bits [32*k +: 32].
  typedef struct {
    logic [511:0] code;
    int           ack;
    int           nsend;
    logic [127:0] exp;
    int           nwe;
    logic [7:0]   maddr;
    logic [31:0]  mval;
    int           nrack;
    int           npw;
  } vec_t;

  function automatic vec_t mk(input logic [511:0] code, input int ack, input int nsend,
                              input logic [127:0] exp, input int nwe, input logic [7:0] maddr,
                              input logic [31:0] mval, input int nrack, input int npw);
    vec_t v;
    v.code = code; v.ack = ack; v.nsend = nsend; v.exp = exp; v.nwe = nwe;
    v.maddr = maddr; v.mval = mval; v.nrack = nrack; v.npw = npw;
    return v;
  endfunction

  task automatic load_prog(input logic [511:0] code);
    for (int i = 0; i < 256; i++) begin
      pmem[i] = 8'h00;
      mmem[i] = 32'h0;
    end
    for (int i = 0; i < 64; i++) pmem[i] = code[8*i +: 8];
    mmem[7] = 32'h0000_DEAD;
    sent_q.delete();
    we_cnt = 0; rack_cnt = 0; pw_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v);
    reset = 1'b0;
    ack_delay = v.ack;
    load_prog(v.code);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
  endtask

  vec_t vecs [12];
  logic [31:0] got;
  logic [511:0] send_prog;
  int n;

  initial begin
    send_prog = 512'({HALT, SEND, 32'h41, LIT});
    vecs[0]  = mk(send_prog, 4, 1, 128'h41, 0, 8'h00, 32'h0, 0, 0);
    vecs[1]  = mk(512'({HALT, STORE, 32'h10, LIT, SUB, 32'h3, LIT, 32'h5, LIT}),
                  1, 0, 128'h0, 1, 8'h10, 32'h2, 0, 0);
    vecs[2]  = mk(512'({HALT, SEND, LOAD, 32'h7, LIT}), 2, 1, 128'hDEAD, 0, 8'h07, 32'hDEAD, 0, 0);
    vecs[3]  = mk(512'({HALT, 32'd6, LOOP, SEND, 32'h78, LIT, LPUSH, 32'h3, LIT}),
                  1, 3, 128'h78_00000078_00000078, 0, 8'h00, 32'h0, 0, 0);
    vecs[4]  = mk(512'({RET, SEND, 32'h41, LIT, HALT, SEND, 32'h42, LIT, 32'd12, CALL}),
                  1, 2, {32'h42, 32'h41}, 0, 8'h00, 32'h0, 0, 0);
    vecs[5]  = mk(512'({HALT, SEND, 32'h2, LIT, HALT, SEND, 32'h1, LIT, 32'd17, JZ, 32'h0, LIT}),
                  1, 1, 128'h2, 0, 8'h00, 32'h0, 0, 0);
    vecs[6]  = mk(512'({HALT, SEND, 32'h2, LIT, HALT, SEND, 32'h1, LIT, 32'd17, JZ, 32'h1, LIT}),
                  1, 1, 128'h1, 0, 8'h00, 32'h0, 0, 0);
    vecs[7]  = mk(512'({HALT, SEND, ADD, 32'h2, LIT, 32'hFFFF_FFFF, LIT, SEND, XOR, SEND, OR,
                        OVER, OVER, SEND, AND, OVER, OVER, 32'h3C, LIT, 32'hF0, LIT}),
                  1, 4, {32'h1, 32'hCC, 32'hFC, 32'h30}, 0, 8'h00, 32'h0, 0, 0);
    vecs[8]  = mk(512'({HALT, SEND, DROP, 32'h8, LIT, 32'h9, LIT, SEND, ADD, DUP, 32'h7, LIT,
                        SEND, SEND, SWAP, 32'h2, LIT, 32'h1, LIT}),
                  2, 4, {32'h9, 32'hE, 32'h2, 32'h1}, 0, 8'h00, 32'h0, 0, 0);
    vecs[9]  = mk(512'({HALT, SEND, 8'hFF, RECV}), 1, 1, 128'h1234, 0, 8'h00, 32'h0, 1, 0);
    vecs[10] = mk(512'({HALT, SEND, SUB, 32'h5, LIT, 32'h3, LIT, BSEL, 32'h0, LIT}),
                  1, 1, 128'hFFFF_FFFE, 0, 8'h00, 32'h0, 0, 0);
    vecs[11] = mk(512'({HALT, PWR, 32'h20, LIT, 32'hCAFE, LIT}), 1, 0, 128'h0, 0, 8'h00, 32'h0, 0, 1);

    // Reset state: everything quiet while reset is held.
    load_prog(send_prog);
    ack_delay = 4;
    repeat (2) @(negedge clk);
    check("rst_pc", 32'(programmem_addr), 32'h0);
    check("rst_send", 32'(global_send), 32'h0);
    check("rst_data", global_data, 32'h0);
    check("rst_enables", 32'(sender_enables), 32'h0);
    check("rst_mem_we", 32'({mainmem_we, programmem_we}), 32'h0);
    check("rst_racks", 32'(receiver_send_acks), 32'h0);
    check("tieoffs", 32'({global_kill, global_incept, global_stream, receiver_kill_acks,
                          receiver_incept_acks, receiver_stream_acks}) |
                     global_self_permission | global_self_address |
                     global_incept_permission | global_incept_address, 32'h0);

    // Send handshake: high from SEND entry through the ack edge, low after it.
    reset = 1'b1;
    n = 0;
    while (!global_send && n < 50) begin @(posedge clk); #1; n++; end
    check("send_seen", 32'(global_send), 32'h1);
    check("send_enables", 32'(sender_enables), 32'h1);
    n = 0;
    while (global_send && n < 50) begin
      if (global_data !== 32'h41) check("send_hold", global_data, 32'h41);
      @(posedge clk); #1; n++;
    end
    check("send_high_cycles", n, 4);
    check("send_count", sent_q.size(), 1);
    got = (sent_q.size() > 0) ? sent_q[0] : 32'hxxxx_xxxx;
    check("send_value", got, 32'h41);

    // Reset while a send is pending.
    reset = 1'b0;
    load_prog(send_prog);
    ack_delay = 1000;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (!global_send && n < 50) begin @(posedge clk); #1; n++; end
    check("midsend_seen", 32'(global_send), 32'h1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midsend_send", 32'(global_send), 32'h0);
    check("midsend_pc", 32'(programmem_addr), 32'h0);
    check("midsend_data", global_data, 32'h0);
    check("midsend_enables", 32'(sender_enables), 32'h0);
    ack_delay = 2;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (sent_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    got = (sent_q.size() > 0) ? sent_q[0] : 32'hxxxx_xxxx;
    check("restart_send", got, 32'h41);

    // Program table.
    for (int k = 0; k < 12; k++) begin
      run_vec(vecs[k]);
      check($sformatf("v%0d nsend", k), sent_q.size(), vecs[k].nsend);
      for (int j = 0; j < vecs[k].nsend; j++) begin
        got = (j < sent_q.size()) ? sent_q[j] : 32'hxxxx_xxxx;
        check($sformatf("v%0d send%0d", k, j), got, vecs[k].exp[32*j +: 32]);
      end
      check($sformatf("v%0d mem_we", k), we_cnt, vecs[k].nwe);
      check($sformatf("v%0d mem[%0h]", k, vecs[k].maddr), mmem[vecs[k].maddr], vecs[k].mval);
      check($sformatf("v%0d racks", k), rack_cnt, vecs[k].nrack);
      check($sformatf("v%0d pwrites", k), pw_cnt, vecs[k].npw);
    end
    // The last table entry is the pwrite program.
    check("pw_addr", pw_addr, 32'h20);
    check("pw_value", pw_val, 32'hCAFE);
    check("pw_mask", pw_mask, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
